preadder_driver: RTL and testbench



---
 rtl/preadd_pkg.sv | 20 ++
 rtl/preadd_skew_pipe.sv | 34 +++
 rtl/preadder_driver.sv | 126 ++++++++++++
 tb/tb_preadder_driver.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preadd_pkg.sv
// rtl/preadd_pkg.sv - shared constants and INMODE[3:1] op encodings for the pre-adder driver
// Contents: DATA_W (pre-adder operand width), preadd_op_e (INMODE[3:1] encodings),
//           OP_BUBBLE (op presented to the pre-adder when no operation is in flight).
package preadd_pkg;

  localparam int DATA_W = 25;

  // Bit 0 gates A to zero, bit 1 enables D, bit 2 selects D - A instead of D + A.
  typedef enum logic [2:0] {
    OP_A    = 3'b000,
    OP_ZERO = 3'b001,
    OP_DPA  = 3'b010,
    OP_D    = 3'b011,
    OP_NEGA = 3'b100,
    OP_DMA  = 3'b110
  } preadd_op_e;

  localparam preadd_op_e OP_BUBBLE = OP_ZERO;

endpackage

// File: rtl/preadd_skew_pipe.sv
// rtl/preadd_skew_pipe.sv - enable-gated delay line with synchronous clear
// Ports: clk_i clock; en_i shift enable; clr_i synchronous clear (wins over en_i);
//        d_i stage input; q_o output delayed by DEPTH enabled cycles (DEPTH = 0 is a wire).
module preadd_skew_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, en_i, clr_i};
    assign q_o = d_i;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/preadder_driver.sv
// rtl/preadder_driver.sv - issue-side sequencer for the DSP pre-adder (USE_DPORT=1)
// Ports: clk, RST (sync, active-high); in_valid/in_ready/in_op/in_a/in_d/in_tag operation stream;
//        flush pipeline discard; D, AMULT_REGA, INMODE, CED, CEAD, RSTD to the pre-adder;
//        out_valid/out_ready/out_tag result stream aligned with AMULT; ops_done completion count.
module preadder_driver
  import preadd_pkg::*;
#(
  parameter int DREG  = 1,
  parameter int ADREG = 1,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_d,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] AMULT_REGA,
  output logic [2:0]        INMODE,
  output logic              CED,
  output logic              CEAD,
  output logic              RSTD,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [15:0]       ops_done
);

  localparam int LAT    = DREG + ADREG;
  localparam int SKEW_W = 1 + TAG_W + 3 + DATA_W;
  localparam int RES_W  = 1 + TAG_W;

  if (LAT == 0) begin : g_lat_check
    $error("preadder_driver: DREG + ADREG must be at least 1");
  end

  logic              advance;
  logic              xfer;
  logic              stage_clr;
  logic [SKEW_W-1:0] skew_in;
  logic [SKEW_W-1:0] skew_out;
  logic [RES_W-1:0]  res_in;
  logic [RES_W-1:0]  res_out;
  logic              sk_valid;
  logic [TAG_W-1:0]  sk_tag;
  logic [2:0]        sk_op;
  logic [DATA_W-1:0] sk_a;
  logic [15:0]       ops_done_q;
  logic [15:0]       ops_done_d;

  // The whole pipeline (driver stages and pre-adder registers) moves in lockstep;
  // a stalled result at the output freezes everything behind it.
  assign advance   = (!out_valid || out_ready) && !flush && !RST;
  assign xfer      = in_valid && advance;
  assign stage_clr = RST || flush;

  assign in_ready = advance;
  assign CED      = advance;
  assign CEAD     = advance;
  assign RSTD     = RST || flush;

  // D goes straight to the pre-adder, whose own D register supplies the DREG delay.
  assign D = xfer ? in_d : '0;

  // Op, A and tag are delayed here so they meet the registered D at the pre-adder.
  assign skew_in = {xfer,
                    (xfer ? in_tag : '0),
                    (xfer ? in_op : 3'(OP_BUBBLE)),
                    (xfer ? in_a : '0)};

  preadd_skew_pipe #(
    .DEPTH (DREG),
    .WIDTH (SKEW_W)
  ) u_d_skew (
    .clk_i (clk),
    .en_i  (advance),
    .clr_i (stage_clr),
    .d_i   (skew_in),
    .q_o   (skew_out)
  );

  assign {sk_valid, sk_tag, sk_op, sk_a} = skew_out;

  // Bubbles always present the zero op so AD never sees stale operands.
  assign INMODE     = sk_valid ? sk_op : 3'(OP_BUBBLE);
  assign AMULT_REGA = sk_valid ? sk_a : '0;

  // Valid/tag follow the pre-adder AD register so they line up with AMULT.
  assign res_in = {sk_valid, sk_tag};

  preadd_skew_pipe #(
    .DEPTH (ADREG),
    .WIDTH (RES_W)
  ) u_ad_result (
    .clk_i (clk),
    .en_i  (advance),
    .clr_i (stage_clr),
    .d_i   (res_in),
    .q_o   (res_out)
  );

  assign {out_valid, out_tag} = res_out;

  // A result dropped by flush is not counted even if out_ready is high that cycle.
  always_comb begin
    ops_done_d = ops_done_q;
    if (out_valid && out_ready && !flush) begin
      ops_done_d = ops_done_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      ops_done_q <= '0;
    end else begin
      ops_done_q <= ops_done_d;
    end
  end

  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_preadder_driver.sv
// tb/tb_preadder_driver.sv - scoreboard bench for preadder_driver with a pre-adder model attached
module tb_preadder_driver;

  logic        clk;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [24:0] in_a;
  logic [24:0] in_d;
  logic [7:0]  in_tag;
  logic        flush;
  logic [24:0] D;
  logic [24:0] AMULT_REGA;
  logic [2:0]  INMODE;
  logic        CED;
  logic        CEAD;
  logic        RSTD;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_tag;
  logic [15:0] ops_done;

  preadder_driver #(
    .DREG  (1),
    .ADREG (1),
    .TAG_W (8)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_d       (in_d),
    .in_tag     (in_tag),
    .flush      (flush),
    .D          (D),
    .AMULT_REGA (AMULT_REGA),
    .INMODE     (INMODE),
    .CED        (CED),
    .CEAD       (CEAD),
    .RSTD       (RSTD),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pre-adder with USE_DPORT=1, DREG=1, ADREG=1.
  logic [24:0] pa_dreg;
  logic [24:0] pa_adreg;
  logic [24:0] pa_dsel;
  logic [24:0] pa_asel;
  logic [24:0] pa_ad;
  logic [24:0] amult;

  assign pa_dsel = INMODE[1] ? pa_dreg : 25'd0;
  assign pa_asel = INMODE[0] ? 25'd0 : AMULT_REGA;
  assign pa_ad   = INMODE[2] ? (pa_dsel - pa_asel) : (pa_dsel + pa_asel);
  assign amult   = pa_adreg;

  always @(posedge clk) begin
    if (RSTD) begin
      pa_dreg  <= 25'd0;
      pa_adreg <= 25'd0;
    end else begin
      if (CED)  pa_dreg  <= D;
      if (CEAD) pa_adreg <= pa_ad;
    end
  end

  typedef struct {
    logic [7:0]  tag;
    logic [24:0] amult;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [15:0] exp_done = 16'd0;
  int          pops = 0;

  function automatic logic [24:0] model(input logic [2:0] op, input logic [24:0] a,
                                        input logic [24:0] d);
    case (op)
      3'b000:  return a;
      3'b001:  return 25'd0;
      3'b010:  return d + a;
      3'b011:  return d;
      3'b100:  return 25'd0 - a;
      3'b101:  return 25'd0;
      3'b110:  return d - a;
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Called between edges with inputs already driven: scores this cycle, then advances one clock.
  task automatic tick();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      sb.push_back('{tag: in_tag, amult: model(in_op, in_a, in_d)});
    end
    if (out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_tag", {24'd0, out_tag}, {24'd0, e.tag});
        chk("amult", {7'd0, amult}, {7'd0, e.amult});
        exp_done = exp_done + 16'd1;
        pops++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [24:0] a, input logic [24:0] d,
                       input logic [7:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_d     = d;
    in_tag   = tag;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pops0;
    logic [15:0] need;

    RST       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'b001;
    in_a      = '0;
    in_d      = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_D", {7'd0, D}, 32'd0);
    chk("rst_amult_rega", {7'd0, AMULT_REGA}, 32'd0);
    chk("rst_inmode", {29'd0, INMODE}, 32'd1);
    chk("rst_ced", {31'd0, CED}, 32'd0);
    chk("rst_cead", {31'd0, CEAD}, 32'd0);
    chk("rst_rstd", {31'd0, RSTD}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_tag", {24'd0, out_tag}, 32'd0);
    chk("rst_ops_done", {16'd0, ops_done}, 32'd0);
    RST = 1'b0;
    @(negedge clk);

    // Single op, latency 2
    drive(3'b010, 25'd3, 25'd5, 8'h11);
    #1;
    chk("c0_in_ready", {31'd0, in_ready}, 32'd1);
    chk("c0_D", {7'd0, D}, 32'd5);
    tick();
    in_valid = 1'b0;
    #1;
    chk("c1_out_valid", {31'd0, out_valid}, 32'd0);
    chk("c1_inmode", {29'd0, INMODE}, 32'd2);
    chk("c1_amult_rega", {7'd0, AMULT_REGA}, 32'd3);
    tick();
    #1;
    chk("c2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_amult", {7'd0, amult}, 32'd8);
    chk("c2_out_tag", {24'd0, out_tag}, 32'h11);
    tick();
    chk("c3_ops_done", {16'd0, ops_done}, 32'd1);

    // Subtract / negate / zero ops
    drive(3'b110, 25'd7, 25'd5, 8'h21); tick();
    drive(3'b100, 25'd1, 25'd9, 8'h22); tick();
    drive(3'b001, 25'h155_5555, 25'h0AA_AAAA, 8'h23); tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Back-to-back stream of 10 ops
    pops0 = pops;
    for (int i = 0; i < 10; i++) begin
      drive(3'($urandom_range(0, 7)), 25'($urandom), 25'($urandom), 8'(8'h30 + i));
      #1;
      if (i >= 2) chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("b2b_drain_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    tick();
    chk("b2b_count", pops, pops0 + 10);

    // Backpressure: out_ready low 5 cycles with input always valid
    out_ready = 1'b0;
    drive(3'b010, 25'd100, 25'd200, 8'h40); tick();
    drive(3'b110, 25'd50, 25'd20, 8'h41);   tick();
    for (int i = 0; i < 3; i++) begin
      drive(3'b011, 25'd1, 25'd2, 8'(8'h42 + i));
      #1;
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_ced", {31'd0, CED}, 32'd0);
      chk("stall_cead", {31'd0, CEAD}, 32'd0);
      chk("stall_tag", {24'd0, out_tag}, {24'd0, sb[0].tag});
      chk("stall_amult", {7'd0, amult}, {7'd0, sb[0].amult});
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    pops0 = pops;
    repeat (3) tick();
    chk("stall_drain_count", pops, pops0 + 2);

    // Flush while a result is stalled
    out_ready = 1'b0;
    drive(3'b010, 25'd1, 25'd2, 8'h50); tick();
    drive(3'b011, 25'd3, 25'd4, 8'h51); tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    chk("flush_rstd", {31'd0, RSTD}, 32'd1);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    sb.delete();
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(3'b011, 25'd4, 25'd9, 8'h52);
    #1;
    chk("post_flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_flush_rstd", {31'd0, RSTD}, 32'd0);
    chk("post_flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_flush_ops_done", {16'd0, ops_done}, {16'd0, exp_done});
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("post_flush_result_valid", {31'd0, out_valid}, 32'd1);
    chk("post_flush_amult", {7'd0, amult}, 32'd9);
    tick();

    // Counter wrap
    need = 16'hFFFE - exp_done;
    for (int i = 0; i < int'(need); i++) begin
      drive(3'b000, 25'(i), 25'd0, 8'(i));
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    chk("ops_done_fffe", {16'd0, ops_done}, 32'h0000_FFFE);
    drive(3'b010, 25'd1, 25'd1, 8'hE0); tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("ops_done_ffff", {16'd0, ops_done}, 32'h0000_FFFF);
    drive(3'b010, 25'd2, 25'd2, 8'hE1); tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("ops_done_wrap", {16'd0, ops_done}, 32'h0000_0000);

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
